// File: rtl/aemb2_dwb_pkg.sv
// Shared definitions for the AEMB2 data-bus SRAM responder: FSM state
// encodings and the byte-lane select constants also used by the initiator.
package aemb2_dwb_pkg;

    localparam logic [1:0] DWB_IDLE = 2'd0;
    localparam logic [1:0] DWB_WAIT = 2'd1;
    localparam logic [1:0] DWB_ACK  = 2'd2;

    localparam logic [3:0] DWB_SEL_WORD = 4'hF;
    localparam logic [3:0] DWB_SEL_HI   = 4'hC;
    localparam logic [3:0] DWB_SEL_LO   = 4'h3;

endpackage

// File: rtl/aemb2_dwb_sram_bank.sv
// Single-port word RAM built as four independent 8-bit lanes, each with its
// own write enable and a registered read port. Lane n holds data[8n+7:8n].
module aemb2_dwb_sram_bank #(
    parameter int AEMB_MEM = 10
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                rd_en,
    input  logic [AEMB_MEM-1:0] rd_addr,
    input  logic [3:0]          wr_en,
    input  logic [AEMB_MEM-1:0] wr_addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data
);

    localparam int DEPTH = 2 ** AEMB_MEM;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_q;

            // Byte-lane write; contents are never reset.
            always_ff @(posedge gclk) begin
                if (wr_en[gi]) begin
                    lane_mem[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            // Registered read; holds the last word read between accesses.
            always_ff @(posedge gclk or posedge grst) begin
                if (grst) begin
                    lane_q <= 8'h00;
                end else if (rd_en) begin
                    lane_q <= lane_mem[rd_addr];
                end
            end

            assign rd_data[8*gi +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/aemb2_dwb_sram.sv
// Wishbone data-bus SRAM responder for the AEMB2 core. Decodes stb/cyc,
// optionally inserts wait states, and returns a one-cycle ack. Writes commit
// on the edge leaving ACK; read data is registered on the edge entering ACK.
// Optional feature macro: AEMB2_DWB_WST_EN builds the WAIT state and the
// wait-state counter so that AEMB_WST is honoured; otherwise access is
// fixed at zero wait states.
module aemb2_dwb_sram
    import aemb2_dwb_pkg::*;
#(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_MEM = 10,
    parameter int AEMB_WST = 0
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic [AEMB_DWB-1:2] dwb_adr_i,
    input  logic [3:0]          dwb_sel_i,
    input  logic                dwb_stb_i,
    input  logic                dwb_cyc_i,
    input  logic                dwb_wre_i,
    input  logic [31:0]         dwb_dat_i,
    output logic [31:0]         dwb_dat_o,
    output logic                dwb_ack_o
);

    logic [1:0]          state_reg;
    logic [1:0]          state_next;
    logic [AEMB_MEM-1:0] adr_reg;
    logic [3:0]          sel_reg;
    logic                wre_reg;
    logic                req;
    logic [AEMB_MEM-1:0] rd_addr;
    logic                rd_en;
    logic [3:0]          wr_en;

    // Upper address bits alias onto the same RAM and are deliberately ignored.
    logic unused_adr;
    assign unused_adr = ^{1'b0, dwb_adr_i[AEMB_DWB-1:AEMB_MEM+2]};

    assign req = dwb_stb_i & dwb_cyc_i;

`ifdef AEMB2_DWB_WST_EN
    localparam logic [3:0] WST_INIT = (AEMB_WST == 0) ? 4'd0 : 4'(AEMB_WST - 1);

    logic [3:0] wcnt_reg;
    logic [3:0] wcnt_next;

    // Next-state logic with wait-state counting; dropping stb/cyc in WAIT aborts.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            DWB_IDLE: begin
                if (req) begin
                    if (AEMB_WST == 0) begin
                        state_next = DWB_ACK;
                    end else begin
                        state_next = DWB_WAIT;
                        wcnt_next  = WST_INIT;
                    end
                end
            end
            DWB_WAIT: begin
                if (!req) begin
                    state_next = DWB_IDLE;
                end else if (wcnt_reg == 4'd0) begin
                    state_next = DWB_ACK;
                end else begin
                    wcnt_next = wcnt_reg - 4'd1;
                end
            end
            default: state_next = DWB_IDLE;
        endcase
    end

    // Wait-state counter register.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            wcnt_reg <= 4'd0;
        end else begin
            wcnt_reg <= wcnt_next;
        end
    end
`else
    // Next-state logic for the fixed zero-wait cycle IDLE -> ACK -> IDLE.
    always_comb begin
        state_next = DWB_IDLE;
        if ((state_reg == DWB_IDLE) && req) begin
            state_next = DWB_ACK;
        end
    end
`endif

    // State register; reset drops any access in flight, including a pending write.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_reg <= DWB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the request attributes at the accepting edge.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            adr_reg <= '0;
            sel_reg <= 4'h0;
            wre_reg <= 1'b0;
        end else if ((state_reg == DWB_IDLE) && req) begin
            adr_reg <= dwb_adr_i[AEMB_MEM+1:2];
            sel_reg <= dwb_sel_i;
            wre_reg <= dwb_wre_i;
        end
    end

    // A zero-wait access reads on the accepting edge, so use the live address
    // while still in IDLE; otherwise use the captured one.
    assign rd_addr = (state_reg == DWB_IDLE) ? dwb_adr_i[AEMB_MEM+1:2] : adr_reg;
    assign rd_en   = (state_next == DWB_ACK);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wen
            assign wr_en[gi] = (state_reg == DWB_ACK) & wre_reg & sel_reg[gi];
        end
    endgenerate

    aemb2_dwb_sram_bank #(
        .AEMB_MEM (AEMB_MEM)
    ) u_bank (
        .gclk    (gclk),
        .grst    (grst),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .wr_en   (wr_en),
        .wr_addr (adr_reg),
        .wr_data (dwb_dat_i),
        .rd_data (dwb_dat_o)
    );

    assign dwb_ack_o = (state_reg == DWB_ACK);

endmodule

// File: tb/tb_aemb2_dwb_sram.sv
// Directed self-checking bench for aemb2_dwb_sram.
module tb_aemb2_dwb_sram;

`ifdef AEMB2_DWB_WST_EN
    localparam int WST_EFF = 3;
`else
    localparam int WST_EFF = 0;
`endif
    localparam int LAT    = 1 + WST_EFF;
    localparam int PERIOD = 2 + WST_EFF;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic [31:2] dwb_adr_i = '0;
    logic [3:0]  dwb_sel_i = 4'h0;
    logic        dwb_stb_i = 1'b0;
    logic        dwb_cyc_i = 1'b0;
    logic        dwb_wre_i = 1'b0;
    logic [31:0] dwb_dat_i = '0;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    aemb2_dwb_sram #(
        .AEMB_DWB (32),
        .AEMB_MEM (10),
        .AEMB_WST (3)
    ) dut (
        .gclk      (gclk),
        .grst      (grst),
        .dwb_adr_i (dwb_adr_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_stb_i (dwb_stb_i),
        .dwb_cyc_i (dwb_cyc_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_dat_o (dwb_dat_o),
        .dwb_ack_o (dwb_ack_o)
    );

    always #5 gclk = ~gclk;
    always @(posedge gclk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // One bus access from the initiator side; returns read data, latency in
    // edges from the sampling edge, and the cycle number of the ack.
    task automatic access(input string tag, input logic wre, input logic [31:0] badr,
                          input logic [3:0] sel, input logic [31:0] dat,
                          output logic [31:0] rdat, output int ack_cyc);
        int lat;
        dwb_adr_i = badr[31:2];
        dwb_sel_i = sel;
        dwb_wre_i = wre;
        dwb_dat_i = dat;
        dwb_stb_i = 1'b1;
        dwb_cyc_i = 1'b1;
        lat = 0;
        do begin
            @(posedge gclk); #1;
            lat++;
        end while (!dwb_ack_o && lat < 40);
        rdat    = dwb_dat_o;
        ack_cyc = cycle;
        dwb_stb_i = 1'b0;
        dwb_cyc_i = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        @(posedge gclk); #1;
        check({tag, "_ackw"}, 32'(dwb_ack_o), 32'd0);
        $display("txn %s wre=%0b adr=%08h sel=%h dat=%08h rdat=%08h lat=%0d",
                 tag, wre, badr, sel, dat, rdat, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int          c1, c2;
        logic        saw_ack;

        // Reset
        #12;
        check("rst_ack", 32'(dwb_ack_o), 32'd0);
        check("rst_dat", dwb_dat_o, 32'h0);
        @(posedge gclk); #1;
        grst = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge gclk); #1;
            if (dwb_ack_o) saw_ack = 1'b1;
        end
        check("idle_noack", 32'(saw_ack), 32'd0);

        // Word write then read
        access("wr_word", 1'b1, 32'h010, 4'hF, 32'hDEADBEEF, rd, c1);
        access("rd_word", 1'b0, 32'h010, 4'h0, 32'h0, rd, c1);
        check("rd_word_dat", rd, 32'hDEADBEEF);
        check("dat_hold", dwb_dat_o, 32'hDEADBEEF);

        // Byte lane write (lane 1 = bits 15:8)
        access("wr_lane1", 1'b1, 32'h010, 4'h2, 32'h5A5A5A5A, rd, c1);
        access("rd_lane1", 1'b0, 32'h010, 4'hF, 32'h0, rd, c1);
        check("rd_lane1_dat", rd, 32'hDEAD5AEF);

        // sel=0 write is acked and changes nothing
        access("wr_sel0", 1'b1, 32'h010, 4'h0, 32'h01234567, rd, c1);
        access("rd_sel0", 1'b0, 32'h010, 4'hF, 32'h0, rd, c1);
        check("rd_sel0_dat", rd, 32'hDEAD5AEF);

        // Upper address bits alias, and a high-lane write
        access("wr_hi", 1'b1, 32'h014, 4'hC, 32'hCAFEF00D, rd, c1);
        access("rd_alias", 1'b0, 32'h1010, 4'hF, 32'h0, rd, c1);
        check("rd_alias_dat", rd, 32'hDEAD5AEF);

        // Back-to-back reads: access period
        access("b2b_0", 1'b0, 32'h014, 4'hF, 32'h0, rd, c1);
        check("b2b_0_dat", {rd[31:16], 16'h0}, 32'hCAFE0000);
        access("b2b_1", 1'b0, 32'h010, 4'hF, 32'h0, rd, c2);
        check("b2b_period", 32'(c2 - c1), 32'(PERIOD));
        check("b2b_1_dat", rd, 32'hDEAD5AEF);

`ifdef AEMB2_DWB_WST_EN
        // Abort during WAIT: no ack, no write
        access("wr_020", 1'b1, 32'h020, 4'hF, 32'h12345678, rd, c1);
        dwb_adr_i = 30'(32'h020 >> 2);
        dwb_sel_i = 4'hF;
        dwb_wre_i = 1'b1;
        dwb_dat_i = 32'hAAAAAAAA;
        dwb_stb_i = 1'b1;
        dwb_cyc_i = 1'b1;
        @(posedge gclk); #1;
        @(posedge gclk); #1;
        dwb_cyc_i = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge gclk); #1;
            if (dwb_ack_o) saw_ack = 1'b1;
        end
        dwb_stb_i = 1'b0;
        check("abort_noack", 32'(saw_ack), 32'd0);
        @(posedge gclk); #1;
        access("rd_020", 1'b0, 32'h020, 4'hF, 32'h0, rd, c1);
        check("abort_dat", rd, 32'h12345678);
`endif

        // Reset mid-access: pending write dropped, next access normal
        access("wr_030", 1'b1, 32'h030, 4'hF, 32'h11111111, rd, c1);
        dwb_adr_i = 30'(32'h030 >> 2);
        dwb_sel_i = 4'hF;
        dwb_wre_i = 1'b1;
        dwb_dat_i = 32'h22222222;
        dwb_stb_i = 1'b1;
        dwb_cyc_i = 1'b1;
        @(posedge gclk); #1;
        check("pre_rst_ack", 32'(dwb_ack_o), 32'(WST_EFF == 0));
        grst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(dwb_ack_o), 32'd0);
        check("mid_rst_dat", dwb_dat_o, 32'h0);
        dwb_stb_i = 1'b0;
        dwb_cyc_i = 1'b0;
        @(posedge gclk); #1;
        check("rst_hold_ack", 32'(dwb_ack_o), 32'd0);
        grst = 1'b0;
        @(posedge gclk); #1;
        access("rd_030", 1'b0, 32'h030, 4'hF, 32'h0, rd, c1);
        check("rst_drop_dat", rd, 32'h11111111);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
